// File: rtl/line_buffer3_pkg.sv
// Shared types and constants for the three-row sliding line buffer.
package line_buffer3_pkg;

    localparam int unsigned DefBitDepth = 8;
    localparam int unsigned BankIdxW    = 2;

    typedef logic [BankIdxW-1:0] bank_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStream,
        StDone
    } state_e;

    // Bank indices wrap naturally mod 4 through the 2-bit type.
    function automatic bank_idx_t bank_add(bank_idx_t base, bank_idx_t off);
        return base + off;
    endfunction

endpackage

// File: rtl/line_buffer3_if.sv
// Pixel-in / column-out handshake bundle for line_buffer3.
interface line_buffer3_if
    import line_buffer3_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = DefBitDepth
);

    logic                 start;
    logic [BIT_DEPTH-1:0] pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 shift_buffer;
    logic [BIT_DEPTH-1:0] out_l1;
    logic [BIT_DEPTH-1:0] out_l2;
    logic [BIT_DEPTH-1:0] out_l3;
    logic                 col_valid;
    logic                 row_done;
    logic                 done;

    modport master (
        output start, pix_in, pix_valid, shift_buffer,
        input  pix_ready, out_l1, out_l2, out_l3, col_valid, row_done, done
    );

    modport slave (
        input  start, pix_in, pix_valid, shift_buffer,
        output pix_ready, out_l1, out_l2, out_l3, col_valid, row_done, done
    );

endinterface

// File: rtl/line_buffer3_row_bank.sv
// One image row of storage: single write port, single asynchronous read port.
module line_buffer3_row_bank #(
    parameter  int unsigned BIT_DEPTH = 8,
    parameter  int unsigned DEPTH     = 16,
    localparam int unsigned IdxW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IdxW-1:0]      waddr,
    input  logic [BIT_DEPTH-1:0] wdata,
    input  logic [IdxW-1:0]      raddr,
    output logic [BIT_DEPTH-1:0] rdata
);

    logic [BIT_DEPTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/line_buffer3.sv
// Four-bank line buffer presenting 3-row pixel columns to a downstream 3x3 convolver.
module line_buffer3
    import line_buffer3_pkg::*;
#(
    parameter int unsigned BIT_DEPTH  = DefBitDepth,
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16
) (
    input logic           clk,
    input logic           rst,
    line_buffer3_if.slave bus
);

    localparam int unsigned ColW = $clog2(IMG_WIDTH + 1);
    localparam int unsigned IdxW = $clog2(IMG_WIDTH);
    // Wide enough that rows_out + 4 cannot overflow at the maximum height.
    localparam int unsigned RowW = 9;

    localparam logic [ColW-1:0] LastCol   = ColW'(IMG_WIDTH - 1);
    localparam logic [ColW-1:0] ColEnd    = ColW'(IMG_WIDTH);
    localparam logic [RowW-1:0] RowsTotal = RowW'(IMG_HEIGHT);
    localparam logic [RowW-1:0] LastWin   = RowW'(IMG_HEIGHT - 3);
    localparam logic [RowW-1:0] FillRows  = RowW'(2);

    state_e          state_q, state_d;
    bank_idx_t       wr_bank_q, wr_bank_d;
    bank_idx_t       top_bank_q, top_bank_d;
    logic [ColW-1:0] wr_col_q, wr_col_d;
    logic [ColW-1:0] rd_col_q, rd_col_d;
    logic [RowW-1:0] rows_wr_q, rows_wr_d;
    logic [RowW-1:0] rows_out_q, rows_out_d;
    logic            row_done_q, row_done_d;

    logic spare_full, pix_ready, accept, row_wrap, col_valid, shift, rotate, finish;
    logic [3:0]           bank_we;
    logic [BIT_DEPTH-1:0] rd_data [4];

    for (genvar b = 0; b < 4; b++) begin : g_bank
        line_buffer3_row_bank #(
            .BIT_DEPTH (BIT_DEPTH),
            .DEPTH     (IMG_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_col_q[IdxW-1:0]),
            .wdata (bus.pix_in),
            .raddr (rd_col_q[IdxW-1:0]),
            .rdata (rd_data[b])
        );
    end

    always_comb begin
        // Spare bank (top+3) holds row rows_out+3; full once that row is written.
        spare_full = rows_wr_q >= (rows_out_q + RowW'(4));
        pix_ready  = 1'b0;
        unique case (state_q)
            StFill:   pix_ready = 1'b1;
            StStream: pix_ready = !spare_full && (rows_wr_q < RowsTotal);
            default:  pix_ready = 1'b0;
        endcase
        accept    = bus.pix_valid && pix_ready;
        row_wrap  = accept && (wr_col_q == LastCol);
        col_valid = (state_q == StStream) && (rd_col_q < ColEnd);
        shift     = col_valid && bus.shift_buffer;
        // A write finishing the spare row this cycle is enough to rotate.
        rotate    = (state_q == StStream) && (rd_col_q == ColEnd) &&
                    (spare_full || row_wrap) && (rows_out_q < LastWin);
        finish    = shift && (rd_col_q == LastCol) && (rows_out_q == LastWin);
        for (int b = 0; b < 4; b++) begin
            bank_we[b] = accept && (wr_bank_q == bank_idx_t'(b));
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        top_bank_d = top_bank_q;
        wr_col_d   = wr_col_q;
        rd_col_d   = rd_col_q;
        rows_wr_d  = rows_wr_q;
        rows_out_d = rows_out_q;
        row_done_d = 1'b0;

        if (accept) begin
            if (row_wrap) begin
                wr_col_d  = '0;
                wr_bank_d = bank_add(wr_bank_q, bank_idx_t'(1));
                rows_wr_d = rows_wr_q + RowW'(1);
            end else begin
                wr_col_d = wr_col_q + ColW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StFill;
                    wr_bank_d  = '0;
                    top_bank_d = '0;
                    wr_col_d   = '0;
                    rd_col_d   = '0;
                    rows_wr_d  = '0;
                    rows_out_d = '0;
                end
            end
            StFill: begin
                if (row_wrap && (rows_wr_q == FillRows)) begin
                    state_d    = StStream;
                    top_bank_d = '0;
                    rd_col_d   = '0;
                    rows_out_d = '0;
                end
            end
            StStream: begin
                if (rotate) begin
                    top_bank_d = bank_add(top_bank_q, bank_idx_t'(1));
                    rd_col_d   = '0;
                    rows_out_d = rows_out_q + RowW'(1);
                    row_done_d = 1'b1;
                end else if (shift) begin
                    rd_col_d = rd_col_q + ColW'(1);
                end
                if (finish) begin
                    state_d    = StDone;
                    row_done_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_bank_q  <= '0;
            top_bank_q <= '0;
            wr_col_q   <= '0;
            rd_col_q   <= '0;
            rows_wr_q  <= '0;
            rows_out_q <= '0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            top_bank_q <= top_bank_d;
            wr_col_q   <= wr_col_d;
            rd_col_q   <= rd_col_d;
            rows_wr_q  <= rows_wr_d;
            rows_out_q <= rows_out_d;
            row_done_q <= row_done_d;
        end
    end

    always_comb begin
        bus.pix_ready = pix_ready;
        bus.col_valid = col_valid;
        bus.row_done  = row_done_q;
        bus.done      = (state_q == StDone);
        bus.out_l1    = '0;
        bus.out_l2    = '0;
        bus.out_l3    = '0;
        if (col_valid) begin
            bus.out_l1 = rd_data[top_bank_q];
            bus.out_l2 = rd_data[bank_add(top_bank_q, bank_idx_t'(1))];
            bus.out_l3 = rd_data[bank_add(top_bank_q, bank_idx_t'(2))];
        end
    end

endmodule

// File: tb/tb_line_buffer3.sv
// Scoreboard bench for line_buffer3: columns predicted from the image array, checked on consume.
module tb_line_buffer3;

    localparam int BD = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst;

    line_buffer3_if #(.BIT_DEPTH(BD)) bus ();

    line_buffer3 #(
        .BIT_DEPTH  (BD),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    int row_done_cnt = 0;
    int done_cnt = 0;
    int consumed = 0;
    int idx = 0;
    logic [BD-1:0] img [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cur_col();
        return {8'h00, bus.out_l1, bus.out_l2, bus.out_l3};
    endfunction

    // Monitor: every consumed column is compared with the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.col_valid && bus.shift_buffer) begin
                consumed++;
                if (exp_q.size() == 0) check("extra_column", cur_col(), 32'hffff_ffff);
                else check("column", cur_col(), exp_q.pop_front());
            end
            if (bus.row_done) row_done_cnt++;
            if (bus.done) done_cnt++;
        end
    end

    task automatic fill_image(input bit nominal);
        for (int i = 0; i < N; i++) img[i] = nominal ? BD'(i) : BD'($urandom_range(255));
    endtask

    // Window row r column c is rows r, r+1, r+2 of the image at column c.
    task automatic push_expected();
        for (int r = 0; r <= H - 3; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back({8'h00, img[r*W+c], img[(r+1)*W+c], img[(r+2)*W+c]});
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic step(input bit valid, input bit shift);
        bus.pix_valid    = valid;
        bus.pix_in       = (idx < N) ? img[idx] : BD'(idx);
        bus.shift_buffer = shift;
        @(negedge clk);
        if (bus.pix_valid && bus.pix_ready) idx++;
        @(posedge clk); #1;
    endtask

    task automatic outputs_zero(input string name);
        check(name, {4'h0, bus.pix_ready, bus.col_valid, bus.row_done, bus.done,
                     bus.out_l1, bus.out_l2, bus.out_l3}, 32'h0);
    endtask

    task automatic run_image(input bit nominal, input int vpct, input int spct, input int stall_at);
        int cyc = 0;
        int stall_cnt = 0;
        bit seen_done = 1'b0;
        bit v;
        fill_image(nominal);
        push_expected();
        idx = 0;
        row_done_cnt = 0;
        done_cnt = 0;
        pulse_start();
        while (!seen_done && cyc < 600) begin
            v = (idx < N) && ($urandom_range(99) < vpct);
            if (stall_at >= 0 && idx == stall_at && stall_cnt < 10) begin
                v = 1'b0;
                stall_cnt++;
                if (stall_cnt == 10) check("underflow_col_valid", 32'(bus.col_valid), 32'h0);
            end
            // start outside IDLE must be ignored
            bus.start        = ($urandom_range(7) == 0);
            bus.pix_valid    = v;
            bus.pix_in       = (idx < N) ? img[idx] : '0;
            bus.shift_buffer = ($urandom_range(99) < spct);
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) idx++;
            if (bus.done) seen_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start        = 1'b0;
        bus.pix_valid    = 1'b0;
        bus.shift_buffer = 1'b0;
        check("done_seen", 32'(seen_done), 32'h1);
        check("pixels_accepted", 32'(idx), 32'(N));
        check("columns_left", 32'(exp_q.size()), 32'h0);
        check("row_done_count", 32'(row_done_cnt), 32'(H - 2));
        check("done_count", 32'(done_cnt), 32'h1);
        check("idle_pix_ready", 32'(bus.pix_ready), 32'h0);
        check("idle_done", 32'(bus.done), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.pix_in       = '0;
        bus.pix_valid    = 1'b0;
        bus.shift_buffer = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outputs_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal raster, then underflow stall after pixel 11.
        run_image(1'b1, 100, 100, -1);
        run_image(1'b1, 100, 100, 12);

        // Back-pressure: nothing consumed, spare bank fills, pixel 16 refused.
        fill_image(1'b1);
        idx = 0;
        pulse_start();
        repeat (30) step(1'b1, 1'b0);
        bus.pix_valid = 1'b0;
        check("bp_accepted", 32'(idx), 32'd16);
        check("bp_pix_ready", 32'(bus.pix_ready), 32'h0);
        check("bp_col_valid", 32'(bus.col_valid), 32'h1);
        check("bp_column", cur_col(), 32'h0000_0408);
        rst = 1'b1;
        #1;
        outputs_zero("bp_reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-stream at rd_col = 2, then a fresh image.
        fill_image(1'b1);
        push_expected();
        idx = 0;
        consumed = 0;
        cyc = 0;
        pulse_start();
        while (consumed < 2 && cyc < 100) begin
            step(1'b1, 1'b1);
            cyc++;
        end
        check("midrst_reached", 32'(consumed), 32'd2);
        bus.pix_valid    = 1'b0;
        bus.shift_buffer = 1'b0;
        rst = 1'b1;
        #1;
        outputs_zero("midrst_outputs");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) step(1'b1, 1'b1);
        check("midrst_needs_start", {30'h0, bus.pix_ready, bus.col_valid}, 32'h0);
        bus.pix_valid    = 1'b0;
        bus.shift_buffer = 1'b0;
        run_image(1'b1, 100, 100, -1);

        // Randomised images with random valid/shift duty.
        for (int k = 0; k < 8; k++) begin
            run_image(1'b0, 30 + $urandom_range(70), 30 + $urandom_range(70), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer3.md
LINE_BUFFER3 -- requirements
Module: line_buffer3

Interface
REQ-001 Parameter BIT_DEPTH, default 8, pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 16, pixels per row; legal range 4..255.
REQ-003 Parameter IMG_HEIGHT, default 16, rows per image; legal range 3..255.
REQ-004 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port start, input, 1, begin a new image; sampled only in IDLE.
REQ-007 Port pix_in, input, BIT_DEPTH, raster-order pixel stream.
REQ-008 Port pix_valid, input, 1, pix_in holds a valid pixel.
REQ-009 Port pix_ready, output, 1, block accepts pix_in this cycle.
REQ-010 Port shift_buffer, input, 1, downstream convolve consumes the current column.
REQ-011 Ports out_l1, out_l2, out_l3, output, BIT_DEPTH each, one column: oldest row, middle row, newest row.
REQ-012 Port col_valid, output, 1, out_l1..out_l3 hold a valid column.
REQ-013 Port row_done, output, 1, one-cycle pulse after the last column of a window row is consumed.
REQ-014 Port done, output, 1, one-cycle pulse when the image is complete.

Function
REQ-015 Storage: 4 row banks of IMG_WIDTH x BIT_DEPTH; 3 banks are read while the 4th is written.
REQ-016 A pixel is accepted when pix_valid and pix_ready are both high in the same cycle; it is written at (wr_bank, wr_col), and wr_col increments.
REQ-017 When wr_col wraps from IMG_WIDTH-1 to 0, wr_bank increments mod 4 and the rows-written count increments.
REQ-018 IDLE: pix_ready=0, col_valid=0. start moves to FILL and clears all pointers and counters.
REQ-019 FILL: pix_ready=1. After the 3rd row is fully written, the next state is STREAM with top_bank=0 and rd_col=0.
REQ-020 STREAM: out_l1/out_l2/out_l3 combinationally read banks top, top+1 and top+2 (mod 4) at rd_col. col_valid=1 while rd_col < IMG_WIDTH.
REQ-021 STREAM: shift_buffer with col_valid=1 increments rd_col. shift_buffer with col_valid=0 is ignored.
REQ-022 STREAM: pix_ready=1 only while the spare bank is not yet full and rows-written < IMG_HEIGHT. Otherwise pix_ready=0.
REQ-023 Rotation: when rd_col == IMG_WIDTH, the spare bank is full, and rows-output < IMG_HEIGHT-2:
- top_bank increments mod 4;
- rd_col resets to 0;
- row_done pulses;
- rows-output increments.
REQ-024 If rd_col == IMG_WIDTH but the spare bank is not yet full, col_valid=0 and the block waits. Writes continue during the wait.
REQ-025 Completion: consuming the last column of window row IMG_HEIGHT-2 pulses row_done, moves to DONE, and sets pix_ready=0.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 A write completing the spare row and a rotation in the same cycle are both honoured. The new spare bank is the bank just released.
REQ-028 start outside IDLE is ignored. Pixels presented while pix_ready=0 are not consumed.

Reset
REQ-029 rst asserted forces:
- state IDLE;
- all pointers and counters to 0;
- pix_ready, col_valid, row_done and done to 0;
- out_l1..out_l3 to 0.
REQ-030 rst asserted mid-image aborts the image. Bank contents need not be cleared, but none are presented until a new start completes FILL.

Structure
REQ-031 The shared package holds the state enumeration (IDLE, FILL, STREAM, DONE), the default BIT_DEPTH, and a bank-index width constant of 2.
REQ-032 One sub-module, row_bank: a 1-write, 1-asynchronous-read register file of IMG_WIDTH x BIT_DEPTH, instantiated 4 times.

Verification
REQ-033 Nominal case with IMG_WIDTH=4, IMG_HEIGHT=4, pixel = 4*row+col, pix_valid held high:
- after pixel 11 is accepted, col_valid=1 next cycle with (0,4,8);
- the next shifts give (1,5,9), (2,6,10), (3,7,11).
REQ-034 Rotation, same setup: pixels 12..15 are written during streaming; after the 4th shift, row_done pulses and the next column is (4,8,12).
REQ-035 Completion: after column (7,11,15) is shifted, row_done pulses, then done pulses exactly once, then the state is IDLE with pix_ready=0.
REQ-036 Back-pressure: shift_buffer held low after FILL, so the spare bank fills. Required response:
- pix_ready drops to 0 after pixel 15;
- pixel 16 offered with pix_valid high is not accepted;
- out_l1..out_l3 stay at (0,4,8).
REQ-037 Underflow: pix_valid low after pixel 11, with shift_buffer high throughout. Required response:
- col_valid falls after column (3,7,11);
- col_valid stays 0 until pixel 15 is accepted, then (4,8,12) is presented.
REQ-038 Reset mid-STREAM: rst pulsed while rd_col=2. Required response:
- all outputs are 0 immediately;
- start is then required, and a fresh image streams correctly from (0,4,8).
